apb_multi_master: RTL and testbench

Parametrised APB master that turns single processor-bus requests into APB transfers to one of `NUM_SLAVES` slaves. It adds programmable wait states, a ready timeout, and error reporting. It sits between the processor bus and the per-slave APB buses, in the slot above the existing APB slaves that bridge to memory. It generalises the fixed two-slave, 8-bit arrangement to N slaves and configurable widths.

---
 rtl/apb_multi_master.sv | 148 ++++++++++++++
 tb/tb_apb_multi_master.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_multi_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : apb_multi_master
// Brief    : Single-request APB master for NUM_SLAVES slaves. Supports
//            programmable wait states, a ready timeout and abort reporting.
// Revision : 1.0 - initial release
// ============================================================================
module apb_multi_master #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 8,
  parameter int NUM_SLAVES = 4,
  parameter int SEL_W      = $clog2(NUM_SLAVES),
  parameter int TIMEOUT    = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         write,
  input  logic [SEL_W-1:0]             sel,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [7:0]                   wait_cycles,
  output logic [DATA_W-1:0]            rdata,
  output logic                         stable,
  output logic                         error,
  output logic                         busy,
  output logic [NUM_SLAVES-1:0]        psel,
  output logic                         penable,
  output logic                         pwrite,
  output logic [ADDR_W-1:0]            paddr,
  output logic [DATA_W-1:0]            pwdata,
  input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
  input  logic [NUM_SLAVES-1:0]        pready
);

  // The ACCESS counter must reach 255 + TIMEOUT without wrapping.
  localparam int                CNT_W        = $clog2(256 + TIMEOUT);
  localparam logic [SEL_W:0]    c_num_slaves = (SEL_W+1)'(NUM_SLAVES);
  localparam logic [CNT_W-1:0]  c_timeout_m1 = CNT_W'(TIMEOUT - 1);
  localparam logic [NUM_SLAVES-1:0] c_one    = NUM_SLAVES'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t             r_state;
  logic [SEL_W-1:0]   r_sel;
  logic [7:0]         r_wait;
  logic [CNT_W-1:0]   r_cnt;

  logic [DATA_W-1:0]  w_prdata_arr [NUM_SLAVES];
  logic               w_sel_ok;
  logic               w_ready;
  logic               w_waited;
  logic               w_expired;

  generate
    for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_prdata
      assign w_prdata_arr[k] = prdata[k*DATA_W +: DATA_W];
    end
  endgenerate

  // Out-of-range indices can only appear when NUM_SLAVES is not a power of 2.
  assign w_sel_ok  = ({1'b0, sel} < c_num_slaves);
  assign w_ready   = pready[r_sel];
  assign w_waited  = (r_cnt >= CNT_W'(r_wait));
  assign w_expired = (r_cnt == (CNT_W'(r_wait) + c_timeout_m1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_wait  <= '0;
      r_cnt   <= '0;
      rdata   <= '0;
      stable  <= 1'b0;
      error   <= 1'b0;
      busy    <= 1'b0;
      psel    <= '0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= '0;
      pwdata  <= '0;
    end else begin
      stable <= 1'b0;
      error  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (w_sel_ok) begin
              r_state <= S_SETUP;
              r_sel   <= sel;
              r_wait  <= wait_cycles;
              pwrite  <= write;
              paddr   <= addr;
              pwdata  <= wdata;
              psel    <= c_one << sel;
              busy    <= 1'b1;
            end else begin
              // No slave exists at this index: report without touching the bus.
              r_state <= S_DONE;
              stable  <= 1'b1;
              error   <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          r_state <= S_ACCESS;
          penable <= 1'b1;
          r_cnt   <= '0;
        end
        S_ACCESS: begin
          if (w_waited && w_ready) begin
            if (!pwrite) begin
              rdata <= w_prdata_arr[r_sel];
            end
            r_state <= S_DONE;
            stable  <= 1'b1;
            psel    <= '0;
            penable <= 1'b0;
            busy    <= 1'b0;
          end else if (w_expired) begin
            r_state <= S_DONE;
            stable  <= 1'b1;
            error   <= 1'b1;
            psel    <= '0;
            penable <= 1'b0;
            busy    <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_multi_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_apb_multi_master
// Brief    : Directed self-checking bench for apb_multi_master (4- and 3-slave).
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_multi_master;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        write;
  logic [1:0]  sel;
  logic [7:0]  addr;
  logic [7:0]  wdata;
  logic [7:0]  wait_cycles;
  logic [7:0]  rdata;
  logic        stable;
  logic        error;
  logic        busy;
  logic [3:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [7:0]  pwdata;
  logic [31:0] prdata;
  logic [3:0]  pready;

  logic        start3;
  logic [1:0]  sel3;
  logic [7:0]  rdata3;
  logic        stable3;
  logic        error3;
  logic        busy3;
  logic [2:0]  psel3;
  logic        penable3;
  logic        pwrite3;
  logic [7:0]  paddr3;
  logic [7:0]  pwdata3;
  logic [23:0] prdata3;
  logic [2:0]  pready3;

  int checks = 0;
  int fails  = 0;

  apb_multi_master #(.DATA_W(8), .ADDR_W(8), .NUM_SLAVES(4), .TIMEOUT(16)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .start(start), .write(write), .sel(sel),
    .addr(addr), .wdata(wdata), .wait_cycles(wait_cycles), .rdata(rdata),
    .stable(stable), .error(error), .busy(busy), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  apb_multi_master #(.DATA_W(8), .ADDR_W(8), .NUM_SLAVES(3), .TIMEOUT(16)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .start(start3), .write(write), .sel(sel3),
    .addr(addr), .wdata(wdata), .wait_cycles(wait_cycles), .rdata(rdata3),
    .stable(stable3), .error(error3), .busy(busy3), .psel(psel3), .penable(penable3),
    .pwrite(pwrite3), .paddr(paddr3), .pwdata(pwdata3), .prdata(prdata3), .pready(pready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and returns edges-to-stable (0 if never seen) and penable cycles.
  task automatic do_xfer(input logic w, input logic [1:0] s, input logic [7:0] a,
                         input logic [7:0] d, input logic [7:0] wc,
                         output int lat, output int pen, output logic err);
    start = 1'b1; write = w; sel = s; addr = a; wdata = d; wait_cycles = wc;
    lat = 0; pen = 0; err = 1'b0;
    step();
    start = 1'b0;
    for (int i = 1; i <= 400; i++) begin
      if (penable) pen++;
      if (stable) begin
        lat = i;
        err = error;
        break;
      end
      step();
    end
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 1'b0; write = 1'b0; sel = 2'd0; addr = 8'h00; wdata = 8'h00; wait_cycles = 8'd0;
    start3 = 1'b0; sel3 = 2'd0; prdata = 32'h0; pready = 4'h0; prdata3 = 24'h0; pready3 = 3'h0;
    step(); step();
    checks++; if (psel !== 4'b0000) begin fails++; $display("FAIL reset_psel: got %b expected 0000", psel); end
    checks++; if (penable !== 1'b0) begin fails++; $display("FAIL reset_penable: got %b expected 0", penable); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if ({stable, error} !== 2'b00) begin fails++; $display("FAIL reset_stable_error: got %b expected 00", {stable, error}); end
    checks++; if ({pwrite, paddr, pwdata, rdata} !== 25'h0) begin fails++; $display("FAIL reset_bus_regs: got %h expected 0", {pwrite, paddr, pwdata, rdata}); end
    checks++; if ({psel3, stable3, busy3, rdata3} !== 13'h0) begin fails++; $display("FAIL reset_dut3: got %h expected 0", {psel3, stable3, busy3, rdata3}); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_write();
    pready = 4'hF;
    start = 1'b1; write = 1'b1; sel = 2'd2; addr = 8'h10; wdata = 8'hA5; wait_cycles = 8'd0;
    step();
    start = 1'b0; addr = 8'h00; wdata = 8'h00; write = 1'b0;
    checks++; if ({psel, penable, busy} !== 6'b0100_0_1) begin fails++; $display("FAIL write_setup: got %b expected 010001", {psel, penable, busy}); end
    checks++; if ({pwrite, paddr, pwdata} !== {1'b1, 8'h10, 8'hA5}) begin fails++; $display("FAIL write_setup_bus: got %h expected 110a5", {pwrite, paddr, pwdata}); end
    step();
    checks++; if ({psel, penable, stable} !== 6'b0100_1_0) begin fails++; $display("FAIL write_access: got %b expected 010010", {psel, penable, stable}); end
    checks++; if (pwdata !== 8'hA5) begin fails++; $display("FAIL write_access_pwdata: got %h expected a5", pwdata); end
    step();
    checks++; if ({stable, error, psel, penable, busy} !== 8'b1_0_0000_0_0) begin fails++; $display("FAIL write_done: got %b expected 10000000", {stable, error, psel, penable, busy}); end
    step();
    checks++; if (stable !== 1'b0) begin fails++; $display("FAIL write_stable_width: got %b expected 0", stable); end
  endtask

  task automatic test_read_wait();
    int lat, pen;
    logic err;
    prdata = 32'h11_22_3C_44;
    pready = 4'hF;
    do_xfer(1'b0, 2'd1, 8'h20, 8'h00, 8'd3, lat, pen, err);
    checks++; if (lat !== 6) begin fails++; $display("FAIL read_wait_latency: got %0d expected 6", lat); end
    checks++; if (pen !== 4) begin fails++; $display("FAIL read_wait_access_cycles: got %0d expected 4", pen); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL read_wait_error: got %b expected 0", err); end
    checks++; if (rdata !== 8'h3C) begin fails++; $display("FAIL read_wait_rdata: got %h expected 3c", rdata); end
  endtask

  task automatic test_timeout();
    int lat, pen;
    logic err;
    prdata = 32'h77_55_66_99;
    pready = 4'b0111;
    do_xfer(1'b0, 2'd3, 8'h30, 8'h00, 8'd0, lat, pen, err);
    checks++; if (lat !== 18) begin fails++; $display("FAIL timeout_latency: got %0d expected 18", lat); end
    checks++; if (pen !== 16) begin fails++; $display("FAIL timeout_access_cycles: got %0d expected 16", pen); end
    checks++; if (err !== 1'b1) begin fails++; $display("FAIL timeout_error: got %b expected 1", err); end
    checks++; if (rdata !== 8'h3C) begin fails++; $display("FAIL timeout_rdata_kept: got %h expected 3c", rdata); end
    pready = 4'hF;
  endtask

  task automatic test_bad_sel();
    pready3 = 3'b111;
    prdata3 = 24'h0;
    start3 = 1'b1; sel3 = 2'd3;
    step();
    start3 = 1'b0;
    checks++; if ({stable3, error3} !== 2'b11) begin fails++; $display("FAIL badsel_pulse: got %b expected 11", {stable3, error3}); end
    checks++; if ({psel3, penable3, busy3} !== 5'b000_0_0) begin fails++; $display("FAIL badsel_no_bus: got %b expected 00000", {psel3, penable3, busy3}); end
    step();
    checks++; if ({stable3, error3, psel3} !== 5'b0) begin fails++; $display("FAIL badsel_after: got %b expected 00000", {stable3, error3, psel3}); end
    write = 1'b1; addr = 8'h6B; wdata = 8'hD2; wait_cycles = 8'd0;
    start3 = 1'b1; sel3 = 2'd2;
    step();
    start3 = 1'b0;
    checks++; if ({psel3, pwrite3, paddr3, pwdata3} !== {3'b100, 1'b1, 8'h6B, 8'hD2}) begin fails++; $display("FAIL dut3_valid_setup: got %h expected %h", {psel3, pwrite3, paddr3, pwdata3}, {3'b100, 1'b1, 8'h6B, 8'hD2}); end
    step(); step();
    checks++; if ({stable3, error3} !== 2'b10) begin fails++; $display("FAIL dut3_valid_done: got %b expected 10", {stable3, error3}); end
    step();
  endtask

  task automatic test_reset_mid();
    int lat, pen, nstab;
    logic err;
    pready = 4'hF;
    start = 1'b1; write = 1'b1; sel = 2'd0; addr = 8'h33; wdata = 8'h5E; wait_cycles = 8'd5;
    step();
    start = 1'b0;
    step(); step();
    checks++; if ({psel, penable} !== 5'b0001_1) begin fails++; $display("FAIL midreset_in_access: got %b expected 00011", {psel, penable}); end
    #3;
    reset_n = 1'b0;
    #1;
    checks++; if ({psel, penable, busy} !== 6'b0) begin fails++; $display("FAIL midreset_async_clear: got %b expected 000000", {psel, penable, busy}); end
    nstab = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (stable) nstab++;
    end
    checks++; if (nstab !== 0) begin fails++; $display("FAIL midreset_no_stable: got %0d expected 0", nstab); end
    reset_n = 1'b1;
    do_xfer(1'b1, 2'd0, 8'h34, 8'h61, 8'd5, lat, pen, err);
    checks++; if ({lat, err} !== {32'd8, 1'b0}) begin fails++; $display("FAIL midreset_recover: got lat %0d err %b expected lat 8 err 0", lat, err); end
  endtask

  task automatic test_back_to_back();
    int nstab;
    prdata = 32'h00_00_00_5A;
    pready = 4'b1110;
    start = 1'b1; write = 1'b0; sel = 2'd0; addr = 8'h44; wait_cycles = 8'd0;
    nstab = 0;
    step();                                  // E0 -> SETUP
    if (stable) nstab++;
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_busy_setup: got %b expected 1", busy); end
    step();                                  // E1 -> ACCESS, pready[0]=0
    if (stable) nstab++;
    step();                                  // E2 sees 0
    if (stable) nstab++;
    step();                                  // E3 sees 0
    if (stable) nstab++;
    pready = 4'b1111;
    step();                                  // E4 sees 1 -> DONE
    if (stable) nstab++;
    checks++; if ({stable, error, rdata} !== {1'b1, 1'b0, 8'h5A}) begin fails++; $display("FAIL b2b_first_done: got %h expected 25a", {stable, error, rdata}); end
    step();                                  // E5 -> IDLE
    if (stable) nstab++;
    checks++; if (nstab !== 1) begin fails++; $display("FAIL b2b_single_completion: got %0d expected 1", nstab); end
    checks++; if ({busy, psel} !== 5'b0) begin fails++; $display("FAIL b2b_idle_gap: got %b expected 00000", {busy, psel}); end
    prdata = 32'h00_00_00_C3;
    step();                                  // E6 -> SETUP of second transfer
    start = 1'b0;
    checks++; if ({busy, psel, penable} !== 6'b1_0001_0) begin fails++; $display("FAIL b2b_second_setup: got %b expected 100010", {busy, psel, penable}); end
    step(); step();
    checks++; if ({stable, rdata} !== {1'b1, 8'hC3}) begin fails++; $display("FAIL b2b_second_done: got %h expected 1c3", {stable, rdata}); end
    step();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_timeout();
    test_bad_sel();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
